// File: rtl/block_accum_if.sv
// block_accum_if: valid/busy sample input channel, valid/busy result output
// channel and the run-time block length select for block_accum.
// master = producer/consumer side, slave = block_accum side.
interface block_accum_if #(
  parameter int DIN_W      = 8,
  parameter int MAX_LOG2_N = 3
);
  localparam int DOUT_W = DIN_W + MAX_LOG2_N;
  localparam int LEN_W  = $clog2(MAX_LOG2_N + 1);

  logic [LEN_W-1:0]  len_log2;
  logic              din_vld;
  logic              din_busy;
  logic [DIN_W-1:0]  din_data;
  logic              dout_busy;
  logic              dout_vld;
  logic [DOUT_W-1:0] dout_data;

  modport master (
    output len_log2, din_vld, din_data, dout_busy,
    input  din_busy, dout_vld, dout_data
  );

  modport slave (
    input  len_log2, din_vld, din_data, dout_busy,
    output din_busy, dout_vld, dout_data
  );
endinterface

// File: rtl/block_accum.sv
// block_accum: sums blocks of 2^len unsigned samples and emits one result per
// block through a single-entry output register, so the next block can be
// accumulated while the current result drains.
// Optional macro BLOCK_ACCUM_AVG_EN: output the rounded block mean instead of
// the raw sum (same latency and handshake).
module block_accum #(
  parameter int DIN_W      = 8,
  parameter int MAX_LOG2_N = 3
) (
  input logic        clk,
  input logic        rst,   // active-low, asynchronous
  block_accum_if.slave bus
);
  localparam int DOUT_W = DIN_W + MAX_LOG2_N;
  localparam int LEN_W  = $clog2(MAX_LOG2_N + 1);
  localparam int CNT_W  = MAX_LOG2_N + 1;

  logic              rdy;       // set on the first edge after reset release
  logic [CNT_W-1:0]  cnt;
  logic [DOUT_W-1:0] acc;
  logic [LEN_W-1:0]  len_q;
  logic [DOUT_W-1:0] out_q;
  logic              out_vld;

  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  len_eff;
  logic [CNT_W-1:0]  last_idx;
  logic              last;
  logic              busy;
  logic              take;
  logic              drain;
  logic [DOUT_W-1:0] sum;
  logic [DOUT_W-1:0] result;

  // Clamp the requested length; use it only for the first sample of a block,
  // afterwards the captured length governs so mid-block changes are ignored.
  always_comb begin
    len_in   = (bus.len_log2 > LEN_W'(MAX_LOG2_N)) ? LEN_W'(MAX_LOG2_N) : bus.len_log2;
    len_eff  = (cnt == '0) ? len_in : len_q;
    last_idx = (CNT_W'(1) << len_eff) - CNT_W'(1);
    last     = (cnt == last_idx);
    sum      = acc + DOUT_W'(bus.din_data);
  end

`ifdef BLOCK_ACCUM_AVG_EN
  logic [DOUT_W:0] half;
  logic [DOUT_W:0] rounded;

  // Rounded mean; one extra bit keeps the rounding add from wrapping.
  always_comb begin
    half    = (len_eff == '0) ? '0 : ((DOUT_W + 1)'(1) << (len_eff - LEN_W'(1)));
    rounded = {1'b0, sum} + half;
    result  = DOUT_W'(rounded >> len_eff);
  end
`else
  // Raw block sum.
  always_comb begin
    result = sum;
  end
`endif

  // Only a block-completing sample stalls, and only if the pending result
  // is not draining this same cycle.
  always_comb begin
    busy  = !rdy || (last && out_vld && bus.dout_busy);
    take  = bus.din_vld && !busy;
    drain = out_vld && !bus.dout_busy;
  end

  assign bus.din_busy  = busy;
  assign bus.dout_vld  = out_vld;
  assign bus.dout_data = out_q;

  // Reset-release flag: input is refused until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdy <= 1'b0;
    else      rdy <= 1'b1;
  end

  // Accumulator, sample counter and captured block length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      acc   <= '0;
      len_q <= '0;
    end else if (take) begin
      if (cnt == '0) len_q <= len_in;
      if (last) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= sum;
      end
    end
  end

  // Single-entry result register; a new completion wins over a drain so
  // back-to-back results keep dout_vld high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (take && last) begin
      out_q   <= result;
      out_vld <= 1'b1;
    end else if (drain) begin
      out_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_block_accum.sv
// tb_block_accum: directed scenario tests for block_accum (default build or
// BLOCK_ACCUM_AVG_EN build, expected values chosen accordingly).
module tb_block_accum;
`ifdef BLOCK_ACCUM_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  block_accum_if #(.DIN_W(8), .MAX_LOG2_N(3)) bus ();
  block_accum_if #(.DIN_W(8), .MAX_LOG2_N(2)) bus2 ();

  block_accum #(.DIN_W(8), .MAX_LOG2_N(3)) dut  (.clk(clk), .rst(rst), .bus(bus));
  block_accum #(.DIN_W(8), .MAX_LOG2_N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int passed = 0;
  int total  = 0;
  int vld_cycles = 0;
  logic [10:0] res_q[$];

  // Record every output transfer (decided at the following rising edge).
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dout_vld) vld_cycles++;
      if (bus.dout_vld && !bus.dout_busy) res_q.push_back(bus.dout_data);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    bus.din_vld  = 1'b1;
    bus.din_data = d;
    forever begin
      @(negedge clk);
      if (!bus.din_busy) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL send_timeout: din_busy stuck at 1, required 0 (sample %0d)", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d);
    int n;
    n = 0;
    bus2.din_vld  = 1'b1;
    bus2.din_data = d;
    forever begin
      @(negedge clk);
      if (!bus2.din_busy) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL send2_timeout: din_busy stuck at 1, required 0 (sample %0d)", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus2.din_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cycle();
    total++; if (bus.din_busy !== 1'b1) $display("FAIL reset_din_busy: got %b want 1", bus.din_busy); else passed++;
    total++; if (bus.dout_vld !== 1'b0) $display("FAIL reset_dout_vld: got %b want 0", bus.dout_vld); else passed++;
    total++; if (bus.dout_data !== 11'd0) $display("FAIL reset_dout_data: got %0d want 0", bus.dout_data); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.din_busy !== 1'b1) $display("FAIL release_busy_before_edge: got %b want 1", bus.din_busy); else passed++;
    cycle();
    total++; if (bus.din_busy !== 1'b0) $display("FAIL release_busy_after_edge: got %b want 0", bus.din_busy); else passed++;
  endtask

  task automatic test_full_block();
    logic [10:0] exp_v;
    exp_v = AVG ? 11'd255 : 11'd2040;
    bus.len_log2 = 2'd3;
    res_q.delete();
    vld_cycles = 0;
    repeat (7) send(8'd255);
    total++; if (bus.dout_vld !== 1'b0) $display("FAIL full_early_vld: got %b want 0", bus.dout_vld); else passed++;
    send(8'd255);
    total++; if (bus.dout_vld !== 1'b1) $display("FAIL full_latency_vld: got %b want 1", bus.dout_vld); else passed++;
    total++; if (bus.dout_data !== exp_v) $display("FAIL full_data: got %0d want %0d", bus.dout_data, exp_v); else passed++;
    repeat (3) cycle();
    total++; if (res_q.size() !== 1) $display("FAIL full_count: got %0d want 1", res_q.size()); else passed++;
    total++; if (vld_cycles !== 1) $display("FAIL full_vld_cycles: got %0d want 1", vld_cycles); else passed++;
  endtask

  task automatic test_passthrough();
    logic [7:0] pt[3];
    pt = '{8'd7, 8'd9, 8'd200};
    bus.len_log2 = 2'd0;
    res_q.delete();
    for (int i = 0; i < 3; i++) begin
      send(pt[i]);
      total++; if (bus.dout_vld !== 1'b1 || bus.dout_data !== {3'b000, pt[i]})
        $display("FAIL pass_result%0d: got vld=%b data=%0d want vld=1 data=%0d", i, bus.dout_vld, bus.dout_data, pt[i]);
      else passed++;
    end
    repeat (2) cycle();
    total++; if (res_q.size() !== 3) $display("FAIL pass_count: got %0d want 3", res_q.size()); else passed++;
  endtask

  task automatic test_clamp();
    logic [9:0] exp_v;
    exp_v = AVG ? 10'd3 : 10'd10;
    bus2.len_log2 = 2'd3;   // above MAX_LOG2_N=2 on this instance
    for (int i = 1; i <= 3; i++) send2(8'(i));
    total++; if (bus2.dout_vld !== 1'b0) $display("FAIL clamp_early_vld: got %b want 0", bus2.dout_vld); else passed++;
    send2(8'd4);
    total++; if (bus2.dout_vld !== 1'b1 || bus2.dout_data !== exp_v)
      $display("FAIL clamp_result: got vld=%b data=%0d want vld=1 data=%0d", bus2.dout_vld, bus2.dout_data, exp_v);
    else passed++;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [10:0] e0, e1, e2;
    e0 = AVG ? 11'd2 : 11'd3;
    e1 = AVG ? 11'd4 : 11'd7;
    e2 = AVG ? 11'd6 : 11'd11;
    bus.len_log2  = 2'd1;
    bus.dout_busy = 1'b1;
    res_q.delete();
    send(8'd1);
    send(8'd2);
    send(8'd3);   // first sample of the next block is still accepted
    bus.din_vld  = 1'b1;
    bus.din_data = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.din_busy !== 1'b1) $display("FAIL bp_stall%0d: din_busy got %b want 1", i, bus.din_busy); else passed++;
      total++; if (bus.dout_vld !== 1'b1 || bus.dout_data !== e0)
        $display("FAIL bp_hold%0d: got vld=%b data=%0d want vld=1 data=%0d", i, bus.dout_vld, bus.dout_data, e0);
      else passed++;
    end
    cycle();
    bus.dout_busy = 1'b0;
    send(8'd4);
    send(8'd5);
    send(8'd6);
    repeat (3) cycle();
    total++; if (res_q.size() !== 3) $display("FAIL bp_count: got %0d want 3", res_q.size()); else passed++;
    if (res_q.size() == 3) begin
      total++; if (res_q[0] !== e0) $display("FAIL bp_r0: got %0d want %0d", res_q[0], e0); else passed++;
      total++; if (res_q[1] !== e1) $display("FAIL bp_r1: got %0d want %0d", res_q[1], e1); else passed++;
      total++; if (res_q[2] !== e2) $display("FAIL bp_r2: got %0d want %0d", res_q[2], e2); else passed++;
    end
  endtask

  task automatic test_len_change();
    logic [10:0] e0;
    e0 = AVG ? 11'd3 : 11'd10;
    bus.len_log2 = 2'd2;
    res_q.delete();
    send(8'd1);
    send(8'd2);
    bus.len_log2 = 2'd0;
    send(8'd3);
    send(8'd4);
    send(8'd5);
    repeat (3) cycle();
    total++; if (res_q.size() !== 2) $display("FAIL len_count: got %0d want 2", res_q.size()); else passed++;
    if (res_q.size() == 2) begin
      total++; if (res_q[0] !== e0) $display("FAIL len_r0: got %0d want %0d", res_q[0], e0); else passed++;
      total++; if (res_q[1] !== 11'd5) $display("FAIL len_r1: got %0d want 5", res_q[1]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e0;
    e0 = AVG ? 11'd1 : 11'd8;
    bus.len_log2 = 2'd3;
    res_q.delete();
    repeat (3) send(8'd1);
    cycle();
    rst = 1'b0;
    cycle();
    total++; if (bus.dout_vld !== 1'b0) $display("FAIL rmid_vld: got %b want 0", bus.dout_vld); else passed++;
    total++; if (bus.din_busy !== 1'b1) $display("FAIL rmid_busy: got %b want 1", bus.din_busy); else passed++;
    cycle();
    rst = 1'b1;
    repeat (8) send(8'd1);
    repeat (3) cycle();
    total++; if (res_q.size() !== 1) $display("FAIL rmid_count: got %0d want 1", res_q.size()); else passed++;
    if (res_q.size() == 1) begin
      total++; if (res_q[0] !== e0) $display("FAIL rmid_r0: got %0d want %0d", res_q[0], e0); else passed++;
    end
  endtask

  task automatic test_avg_vectors();
    logic [10:0] e0, e1;
    e0 = AVG ? 11'd5 : 11'd36;
    e1 = AVG ? 11'd3 : 11'd5;
    bus.len_log2 = 2'd3;
    for (int i = 1; i <= 8; i++) send(8'(i));
    total++; if (bus.dout_data !== e0) $display("FAIL avg_len3: got %0d want %0d", bus.dout_data, e0); else passed++;
    bus.len_log2 = 2'd1;
    send(8'd2);
    send(8'd3);
    total++; if (bus.dout_data !== e1) $display("FAIL avg_len1: got %0d want %0d", bus.dout_data, e1); else passed++;
    cycle();
  endtask

  initial begin
    bus.len_log2  = '0;
    bus.din_vld   = 1'b0;
    bus.din_data  = '0;
    bus.dout_busy = 1'b0;
    bus2.len_log2  = '0;
    bus2.din_vld   = 1'b0;
    bus2.din_data  = '0;
    bus2.dout_busy = 1'b0;
    test_reset();
    test_full_block();
    test_passthrough();
    test_clamp();
    test_backpressure();
    test_len_change();
    test_reset_mid();
    test_avg_vectors();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
